// File: rtl/params_pkg.sv
// Shared core parameters and the write-back buffer entry type.
//   REGISTER_WIDTH : register index width
//   DATA_WIDTH     : result width
//   MUL_FIFO_DEPTH : multiplier result buffer entries (>= 1)
//   wb_entry_t     : {valid, wr_reg, data}; valid is cleared when an entry is squashed
package params_pkg;

  localparam int REGISTER_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int MUL_FIFO_DEPTH = 4;

  typedef struct packed {
    logic                      valid;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of multiplier write-back entries with parallel squash.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i         : write push_entry_i at the tail
//   pop_i          : drop the head entry (caller guarantees non-empty)
//   squash_i       : clear valid on every entry whose wr_reg equals squash_reg_i
//   head_o         : current head entry (meaningful only when !empty_o)
//   full_o/empty_o : occupancy flags
module wb_fifo
  import params_pkg::*;
#(
  parameter int DEPTH = MUL_FIFO_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  wb_entry_t                 push_entry_i,
  input  logic                      pop_i,
  input  logic                      squash_i,
  input  logic [REGISTER_WIDTH-1:0] squash_reg_i,
  output wb_entry_t                 head_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (squash_i) begin
        for (int i = 0; i < DEPTH; i++)
          if (mem[i].wr_reg == squash_reg_i) mem[i].valid <= 1'b0;
      end
      // A push into a full FIFO with a simultaneous pop reuses the head slot;
      // the push assignment comes last so it wins over any squash of that slot.
      if (push_i) begin
        mem[wr_ptr] <= push_entry_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_i) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_o  = mem[rd_ptr];
  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (push_i && full_o) |-> pop_i)
    else $error("wb_fifo: push into full FIFO");

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// ALU results have fixed top priority; multiplier results (unstallable 5-stage
// pipeline) are bypassed when possible, otherwise buffered in wb_fifo. A credit
// counter bounds in-flight multiplies to the buffer depth.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   mul_issue_i           : a multiply enters the pipeline this cycle
//   mul_issue_ok_o        : a credit is available
//   mul_valid_i/_wr_reg_i/_result_i : multiplier result
//   alu_valid_i/_wr_reg_i/_result_i : ALU/memory result
//   rf_we_o/rf_wr_reg_o/rf_wr_data_o : registered register-file write
//   mul_pending_o         : buffered results or outstanding multiplies exist
module wb_arbiter #(
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int MUL_FIFO_DEPTH = params_pkg::MUL_FIFO_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mul_issue_i,
  output logic                      mul_issue_ok_o,
  input  logic                      mul_valid_i,
  input  logic [REGISTER_WIDTH-1:0] mul_wr_reg_i,
  input  logic [DATA_WIDTH-1:0]     mul_result_i,
  input  logic                      alu_valid_i,
  input  logic [REGISTER_WIDTH-1:0] alu_wr_reg_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  output logic                      rf_we_o,
  output logic [REGISTER_WIDTH-1:0] rf_wr_reg_o,
  output logic [DATA_WIDTH-1:0]     rf_wr_data_o,
  output logic                      mul_pending_o
);

  import params_pkg::*;

  localparam int CRED_W = $clog2(MUL_FIFO_DEPTH + 1);

  wb_entry_t                 head;
  wb_entry_t                 push_entry;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      head_live;
  logic                      head_dead;
  logic                      fifo_pop;
  logic                      fifo_push;
  logic                      mul_drop;
  logic                      mul_bypass;
  logic [CRED_W-1:0]         credits;

  logic                      wb_vld_p1;
  logic [REGISTER_WIDTH-1:0] wb_reg_p1;
  logic [DATA_WIDTH-1:0]     wb_data_p1;

  assign head_live = !fifo_empty &&  head.valid;
  assign head_dead = !fifo_empty && !head.valid;

  // A squashed head needs no write port, so it drains even under ALU traffic.
  assign fifo_pop = head_dead || (head_live && !alu_valid_i);

  // The ALU instruction is younger, so a same-register multiply result is stale.
  assign mul_drop   = mul_valid_i && alu_valid_i && (mul_wr_reg_i == alu_wr_reg_i);
  assign mul_bypass = mul_valid_i && !alu_valid_i && fifo_empty;
  assign fifo_push  = mul_valid_i && !mul_drop && !mul_bypass;

  assign push_entry = '{valid: 1'b1, wr_reg: mul_wr_reg_i, data: mul_result_i};

  wb_fifo #(.DEPTH(MUL_FIFO_DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .squash_i     (alu_valid_i),
    .squash_reg_i (alu_wr_reg_i),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  // Up to two retirements per cycle: a squashed-head pop plus a dropped result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits <= CRED_W'(MUL_FIFO_DEPTH);
    end else begin
      credits <= credits + CRED_W'(fifo_pop) + CRED_W'(mul_drop || mul_bypass)
                 - CRED_W'(mul_issue_i);
    end
  end

  // ---- stage p1: registered register-file write ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_vld_p1  <= 1'b0;
      wb_reg_p1  <= '0;
      wb_data_p1 <= '0;
    end else begin
      wb_vld_p1 <= alu_valid_i || head_live || mul_bypass;
      if (alu_valid_i) begin
        wb_reg_p1  <= alu_wr_reg_i;
        wb_data_p1 <= alu_result_i;
      end else if (head_live) begin
        wb_reg_p1  <= head.wr_reg;
        wb_data_p1 <= head.data;
      end else if (mul_bypass) begin
        wb_reg_p1  <= mul_wr_reg_i;
        wb_data_p1 <= mul_result_i;
      end
    end
  end

  assign rf_we_o        = wb_vld_p1;
  assign rf_wr_reg_o    = wb_reg_p1;
  assign rf_wr_data_o   = wb_data_p1;
  assign mul_issue_ok_o = (credits != '0);
  assign mul_pending_o  = !fifo_empty || (credits != CRED_W'(MUL_FIFO_DEPTH));

  a_credit_protocol: assert property (@(posedge clk_i) disable iff (rst_i)
    mul_issue_i |-> (credits != '0))
    else $error("wb_arbiter: multiply issued without a credit");

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import params_pkg::*;

  localparam int DEPTH = MUL_FIFO_DEPTH;
  localparam int RW    = REGISTER_WIDTH;
  localparam int DW    = DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          mul_issue_i;
  logic          mul_issue_ok_o;
  logic          mul_valid_i;
  logic [RW-1:0] mul_wr_reg_i;
  logic [DW-1:0] mul_result_i;
  logic          alu_valid_i;
  logic [RW-1:0] alu_wr_reg_i;
  logic [DW-1:0] alu_result_i;
  logic          rf_we_o;
  logic [RW-1:0] rf_wr_reg_o;
  logic [DW-1:0] rf_wr_data_o;
  logic          mul_pending_o;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mul_issue_i    (mul_issue_i),
    .mul_issue_ok_o (mul_issue_ok_o),
    .mul_valid_i    (mul_valid_i),
    .mul_wr_reg_i   (mul_wr_reg_i),
    .mul_result_i   (mul_result_i),
    .alu_valid_i    (alu_valid_i),
    .alu_wr_reg_i   (alu_wr_reg_i),
    .alu_result_i   (alu_result_i),
    .rf_we_o        (rf_we_o),
    .rf_wr_reg_o    (rf_wr_reg_o),
    .rf_wr_data_o   (rf_wr_data_o),
    .mul_pending_o  (mul_pending_o)
  );

  // Reference model: ordered list of buffered results, a credit count and the
  // write expected on the rf outputs after the coming edge.
  typedef struct {
    bit          v;
    bit [RW-1:0] r;
    bit [DW-1:0] d;
  } ent_t;

  ent_t        q[$];
  int          credits;
  bit          e_we;
  bit [RW-1:0] e_reg;
  bit [DW-1:0] e_data;

  // Multiplier pipeline: a result emerges 5 cycles after its issue.
  bit          stg_v [5];
  bit [RW-1:0] stg_r [5];
  bit [DW-1:0] stg_d [5];
  logic [RW-1:0] nxt_r;
  logic [DW-1:0] nxt_d;

  logic [DW-1:0] rf_shadow [1 << RW];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit iss, input bit av, input bit [RW-1:0] ar,
                            input bit [DW-1:0] ad, input bit mv, input bit [RW-1:0] mr,
                            input bit [DW-1:0] md);
    int ret;
    bit was_empty;
    ret       = 0;
    was_empty = (q.size() == 0);
    e_we      = 1'b0;
    if (av) begin
      e_we = 1'b1; e_reg = ar; e_data = ad;
    end
    if (!was_empty) begin
      if (!q[0].v) begin
        void'(q.pop_front());
        ret++;
      end else if (!av) begin
        e_we = 1'b1; e_reg = q[0].r; e_data = q[0].d;
        void'(q.pop_front());
        ret++;
      end
    end
    if (mv) begin
      if (av && mr == ar) ret++;
      else if (!av && was_empty) begin
        e_we = 1'b1; e_reg = mr; e_data = md;
        ret++;
      end else q.push_back('{1'b1, mr, md});
    end
    if (av) foreach (q[i]) if (q[i].r == ar) q[i].v = 1'b0;
    credits += ret - int'(iss);
  endtask

  task automatic cyc(input bit iss, input bit av, input bit [RW-1:0] ar, input bit [DW-1:0] ad);
    @(negedge clk);
    mul_issue_i  = iss;
    mul_valid_i  = stg_v[4];
    mul_wr_reg_i = stg_r[4];
    mul_result_i = stg_d[4];
    alu_valid_i  = av;
    alu_wr_reg_i = ar;
    alu_result_i = ad;
    model_step(iss, av, ar, ad, stg_v[4], stg_r[4], stg_d[4]);
    for (int k = 4; k > 0; k--) begin
      stg_v[k] = stg_v[k-1]; stg_r[k] = stg_r[k-1]; stg_d[k] = stg_d[k-1];
    end
    stg_v[0] = iss; stg_r[0] = nxt_r; stg_d[0] = nxt_d;
    @(posedge clk);
    #1;
    check("rf_we", rf_we_o, e_we);
    if (e_we) begin
      check("rf_wr_reg", rf_wr_reg_o, e_reg);
      check("rf_wr_data", rf_wr_data_o, e_data);
    end
    if (rf_we_o) rf_shadow[rf_wr_reg_o] = rf_wr_data_o;
    check("issue_ok", mul_issue_ok_o, credits != 0);
    check("pending", mul_pending_o, (q.size() != 0) || (credits != DEPTH));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic clear_model();
    q.delete();
    credits = DEPTH;
    for (int k = 0; k < 5; k++) begin
      stg_v[k] = 1'b0; stg_r[k] = '0; stg_d[k] = '0;
    end
  endtask

  task automatic drive_idle();
    mul_issue_i = 1'b0; mul_valid_i = 1'b0; mul_wr_reg_i = '0; mul_result_i = '0;
    alu_valid_i = 1'b0; alu_wr_reg_i = '0; alu_result_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    nxt_r = '0; nxt_d = '0;
    clear_model();
    for (int i = 0; i < (1 << RW); i++) rf_shadow[i] = '0;
    #12;
    check("reset_we", rf_we_o, 0);
    check("reset_reg", rf_wr_reg_o, 0);
    check("reset_data", rf_wr_data_o, 0);
    check("reset_ok", mul_issue_ok_o, 1);
    check("reset_pending", mul_pending_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // ALU only
    cyc(1'b0, 1'b1, 5'd3, 32'h11);
    check("alu_we", rf_we_o, 1);
    check("alu_reg", rf_wr_reg_o, 3);
    check("alu_data", rf_wr_data_o, 32'h11);
    check("alu_pending", mul_pending_o, 0);

    // Multiplier bypass
    nxt_r = 5; nxt_d = 32'h2A;
    cyc(1'b1, 1'b0, '0, '0);
    check("byp_inflight", mul_pending_o, 1);
    idle(4);
    cyc(1'b0, 1'b0, '0, '0);
    check("byp_we", rf_we_o, 1);
    check("byp_reg", rf_wr_reg_o, 5);
    check("byp_data", rf_wr_data_o, 32'h2A);
    check("byp_cred_back", mul_pending_o, 0);

    // Conflict buffering behind a 3-cycle ALU burst
    nxt_r = 6; nxt_d = 32'h66;
    cyc(1'b1, 1'b0, '0, '0);
    idle(4);
    cyc(1'b0, 1'b1, 5'd1, 32'hA1);
    cyc(1'b0, 1'b1, 5'd1, 32'hA2);
    cyc(1'b0, 1'b1, 5'd1, 32'hA3);
    check("conf_pending", mul_pending_o, 1);
    cyc(1'b0, 1'b0, '0, '0);
    check("conf_reg", rf_wr_reg_o, 6);
    check("conf_data", rf_wr_data_o, 32'h66);
    check("conf_pending_done", mul_pending_o, 0);

    // Squash of a buffered entry
    nxt_r = 7; nxt_d = 32'h77;
    cyc(1'b1, 1'b0, '0, '0);
    idle(4);
    cyc(1'b0, 1'b1, 5'd2, 32'hB2);
    cyc(1'b0, 1'b1, 5'd7, 32'h99);
    cyc(1'b0, 1'b0, '0, '0);
    check("squash_nowrite", rf_we_o, 0);
    check("squash_cred", mul_pending_o, 0);
    idle(3);
    check("squash_final", rf_shadow[7], 32'h99);

    // Same-cycle drop
    nxt_r = 7; nxt_d = 32'h55;
    cyc(1'b1, 1'b0, '0, '0);
    idle(4);
    cyc(1'b0, 1'b1, 5'd7, 32'hAB);
    check("drop_cred", mul_pending_o, 0);
    idle(3);
    check("drop_final", rf_shadow[7], 32'hAB);

    // Credit exhaustion with the ALU continuously busy
    for (int i = 0; i < 4; i++) begin
      nxt_r = RW'(8 + i); nxt_d = DW'(32'hC0 + i);
      cyc(1'b1, 1'b1, 5'd0, DW'(32'hE0 + i));
      check("exh_ok", mul_issue_ok_o, i < 3);
    end
    for (int j = 0; j < 6; j++) cyc(1'b0, 1'b1, 5'd0, DW'(32'hE4 + j));
    check("exh_full_ok", mul_issue_ok_o, 0);
    check("exh_full_pending", mul_pending_o, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, '0, '0);
      check("exh_drain_reg", rf_wr_reg_o, 8 + i);
      check("exh_drain_data", rf_wr_data_o, 32'hC0 + i);
    end

    // Asynchronous reset with 3 entries buffered
    for (int i = 0; i < 3; i++) begin
      nxt_r = RW'(12 + i); nxt_d = DW'(32'hD0 + i);
      cyc(1'b1, 1'b1, 5'd0, DW'(32'hF0 + i));
    end
    for (int j = 0; j < 5; j++) cyc(1'b0, 1'b1, 5'd0, DW'(32'hF3 + j));
    check("pre_rst_pending", mul_pending_o, 1);
    #2;
    rst = 1'b1;
    drive_idle();
    #1;
    check("arst_we", rf_we_o, 0);
    check("arst_reg", rf_wr_reg_o, 0);
    check("arst_data", rf_wr_data_o, 0);
    check("arst_ok", mul_issue_ok_o, 1);
    check("arst_pending", mul_pending_o, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, '0);
      check("arst_nostale", rf_we_o, 0);
    end

    // Randomized traffic with varying ALU density
    for (int n = 0; n < 3000; n++) begin
      bit iss, av;
      int busy;
      busy  = (n / 300) % 4;
      iss   = ($urandom_range(0, 2) != 0) && (credits > 0);
      av    = ($urandom_range(0, 3) < busy);
      nxt_r = RW'($urandom_range(0, 7));
      nxt_d = DW'($urandom);
      cyc(iss, av, RW'($urandom_range(0, 7)), DW'($urandom));
    end
    idle(12);
    check("end_drained", mul_pending_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
